// File: rtl/seat_sprite_controller_pkg.sv
// Shared geometry, colour and width constants for the multi-seat sprite overlay.
// Grid, seat and sprite defaults match the seats background layer.
package seat_sprite_controller_pkg;

  localparam int PIX_W = 10;
  localparam int RGB_W = 12;
  localparam int SEAT_IDX_W = 3;

  localparam int DEF_ROWS = 2;
  localparam int DEF_COLS = 4;
  localparam int DEF_SEAT_W = 40;
  localparam int DEF_SEAT_H = 40;
  localparam int DEF_SEAT_SPACING = 15;
  localparam int DEF_ORIGIN_X = 293;
  localparam int DEF_ORIGIN_Y = 305;
  localparam int DEF_BLINK_FRAMES = 30;

  localparam int W = 32;
  localparam int H = 35;
  localparam int ROW_W = 6;
  localparam int COL_W = 5;

  localparam logic [RGB_W-1:0] KEY_COLOR = 12'h000;

endpackage

// File: rtl/kanye_rom.sv
// Sprite ROM with a one-cycle synchronous read. Columns 28..31 hold the key colour
// so the right edge of the sprite is transparent.
module kanye_rom
  import seat_sprite_controller_pkg::*;
(
  input  logic             clk,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  output logic [RGB_W-1:0] color_data
);

  // NOTE: ROM read data carries no reset; downstream logic qualifies it with a reset hit flag.
  always_ff @(posedge clk) begin
    if (col >= COL_W'(28)) begin
      color_data <= KEY_COLOR;
    end else begin
      color_data <= {row, col, 1'b1};
    end
  end

endmodule

// File: rtl/seat_sprite_controller_hit_decoder.sv
// Stage-0 window decode: finds the lowest-index enabled seat whose sprite box covers
// the current pixel and produces the sprite-local ROM address.
module seat_sprite_controller_hit_decoder
  import seat_sprite_controller_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int SEAT_W = DEF_SEAT_W,
  parameter int SEAT_H = DEF_SEAT_H,
  parameter int SEAT_SPACING = DEF_SEAT_SPACING,
  parameter int ORIGIN_X = DEF_ORIGIN_X,
  parameter int ORIGIN_Y = DEF_ORIGIN_Y
) (
  input  logic [PIX_W-1:0]      h_count_i,
  input  logic [PIX_W-1:0]      v_count_i,
  input  logic [ROWS*COLS-1:0]  mask_i,
  output logic                  hit_o,
  output logic [SEAT_IDX_W-1:0] seat_o,
  output logic [ROW_W-1:0]      row_o,
  output logic [COL_W-1:0]      col_o
);

  localparam int NUM_SEATS = ROWS * COLS;

  function automatic logic [PIX_W:0] seat_x(int k);
    return (PIX_W + 1)'(ORIGIN_X + (k % COLS) * (SEAT_W + SEAT_SPACING) + (SEAT_W - W) / 2);
  endfunction

  function automatic logic [PIX_W:0] seat_y(int k);
    return (PIX_W + 1)'(ORIGIN_Y + (k / COLS) * (SEAT_H + SEAT_SPACING) + (SEAT_H - H) / 2);
  endfunction

  always_comb begin
    logic [PIX_W:0] dx;
    logic [PIX_W:0] dy;
    dx     = '0;
    dy     = '0;
    hit_o  = 1'b0;
    seat_o = '0;
    row_o  = '0;
    col_o  = '0;
    // Descending scan so the lowest matching index is the one left standing; an
    // underflowing subtraction wraps high and falls outside the window test.
    for (int k = NUM_SEATS - 1; k >= 0; k--) begin
      dx = {1'b0, h_count_i} - seat_x(k);
      dy = {1'b0, v_count_i} - seat_y(k);
      if (mask_i[k] && dx < (PIX_W + 1)'(W) && dy < (PIX_W + 1)'(H)) begin
        hit_o  = 1'b1;
        seat_o = SEAT_IDX_W'(k);
        row_o  = dy[ROW_W-1:0];
        col_o  = dx[COL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/seat_sprite_controller.sv
// Multi-seat sprite overlay: frame-synchronous occupancy mask, optional per-frame blink,
// one-cycle pixel pipeline with a key-colour transparent ROM sprite over the background.
module seat_sprite_controller
  import seat_sprite_controller_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int SEAT_W = DEF_SEAT_W,
  parameter int SEAT_H = DEF_SEAT_H,
  parameter int SEAT_SPACING = DEF_SEAT_SPACING,
  parameter int ORIGIN_X = DEF_ORIGIN_X,
  parameter int ORIGIN_Y = DEF_ORIGIN_Y,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                  ClkPort,
  input  logic                  rst,
  input  logic                  bright,
  input  logic [PIX_W-1:0]      hCount,
  input  logic [PIX_W-1:0]      vCount,
  input  logic [RGB_W-1:0]      background,
  input  logic [ROWS*COLS-1:0]  mask_in,
  input  logic                  mask_wr,
  input  logic                  blink_en,
  output logic [RGB_W-1:0]      rgb,
  output logic [ROWS*COLS-1:0]  active_mask,
  output logic [SEAT_IDX_W-1:0] hit_seat,
  output logic                  hit_valid
);

  localparam int NUM_SEATS = ROWS * COLS;
  localparam int CNT_W = $clog2(BLINK_FRAMES) + 1;

  logic [PIX_W-1:0]      vcount_prev_q;
  logic [NUM_SEATS-1:0]  pending_q, active_q;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                  phase_q, phase_d;
  logic                  hit_q, bright_q;
  logic [SEAT_IDX_W-1:0] seat_q;
  logic [RGB_W-1:0]      bg_q;

  logic                  frame_boundary, visible, opaque;
  logic                  dec_hit;
  logic [SEAT_IDX_W-1:0] dec_seat;
  logic [ROW_W-1:0]      rom_row;
  logic [COL_W-1:0]      rom_col;
  logic [RGB_W-1:0]      rom_data;

  assign frame_boundary = (vcount_prev_q != '0) && (vCount == '0);
  assign visible        = phase_q | ~blink_en;

  seat_sprite_controller_hit_decoder #(
    .ROWS(ROWS), .COLS(COLS), .SEAT_W(SEAT_W), .SEAT_H(SEAT_H),
    .SEAT_SPACING(SEAT_SPACING), .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y)
  ) u_hit_decoder (
    .h_count_i(hCount),
    .v_count_i(vCount),
    .mask_i   (active_q & {NUM_SEATS{visible}}),
    .hit_o    (dec_hit),
    .seat_o   (dec_seat),
    .row_o    (rom_row),
    .col_o    (rom_col)
  );

  kanye_rom u_rom (
    .clk       (ClkPort),
    .row       (rom_row),
    .col       (rom_col),
    .color_data(rom_data)
  );

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (!blink_en) begin
      frame_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (frame_boundary) begin
      if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values,
  // which is what makes a mask_wr coincident with a frame boundary land one frame later.
  always_ff @(posedge ClkPort) begin
    if (rst) begin
      vcount_prev_q <= '0;
      pending_q     <= '0;
      active_q      <= '0;
      frame_cnt_q   <= '0;
      phase_q       <= 1'b1;
      hit_q         <= 1'b0;
      seat_q        <= '0;
      bright_q      <= 1'b0;
      bg_q          <= '0;
    end else begin
      vcount_prev_q <= vCount;
      if (mask_wr) pending_q <= mask_in;
      if (frame_boundary) active_q <= pending_q;
      frame_cnt_q   <= frame_cnt_d;
      phase_q       <= phase_d;
      hit_q         <= dec_hit;
      seat_q        <= dec_seat;
      bright_q      <= bright;
      bg_q          <= background;
    end
  end

  assign opaque      = hit_q && (rom_data != KEY_COLOR);
  assign rgb         = !bright_q ? '0 : (opaque ? rom_data : bg_q);
  assign hit_valid   = opaque && bright_q;
  assign active_mask = active_q;
  assign hit_seat    = seat_q;

endmodule

// File: tb/tb_seat_sprite_controller.sv
// Directed bench for seat_sprite_controller; pixel counters are driven directly so frame
// boundaries are produced by jumping vCount to a non-zero row and then back to 0.
module tb_seat_sprite_controller;

  logic        ClkPort = 1'b0;
  logic        rst, bright, mask_wr, blink_en;
  logic [9:0]  hCount, vCount;
  logic [11:0] background, rgb;
  logic [7:0]  mask_in, active_mask;
  logic [2:0]  hit_seat;
  logic        hit_valid;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 ClkPort = ~ClkPort;

  seat_sprite_controller #(.BLINK_FRAMES(2)) dut (
    .ClkPort    (ClkPort),
    .rst        (rst),
    .bright     (bright),
    .hCount     (hCount),
    .vCount     (vCount),
    .background (background),
    .mask_in    (mask_in),
    .mask_wr    (mask_wr),
    .blink_en   (blink_en),
    .rgb        (rgb),
    .active_mask(active_mask),
    .hit_seat   (hit_seat),
    .hit_valid  (hit_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one pixel, clock it in, and sample 1 time unit after the edge.
  task automatic pix(input int h, input int v);
    hCount = 10'(h);
    vCount = 10'(v);
    @(posedge ClkPort);
    #1;
  endtask

  task automatic next_frame();
    pix(0, 100);
    pix(0, 0);
  endtask

  localparam logic [11:0] BG = 12'h5A3;
  // Expected sprite visibility for frames 0..6 with BLINK_FRAMES=2.
  localparam logic [6:0] BLINK_VIS = 7'b0110011;

  initial begin
    rst = 1'b1; bright = 1'b1; mask_wr = 1'b1; mask_in = 8'hFF; blink_en = 1'b0;
    background = BG; hCount = 10'd407; vCount = 10'd362;

    // 1: reset with a mask write held high
    repeat (3) @(posedge ClkPort);
    #1;
    check("reset_rgb", rgb, 12'h000);
    check("reset_active", active_mask, 8'h00);
    check("reset_hit_valid", hit_valid, 1'b0);
    check("reset_hit_seat", hit_seat, 3'd0);
    rst = 1'b0; mask_wr = 1'b0;
    pix(0, 100);
    check("post_reset_bg", rgb, BG);
    next_frame();
    check("reset_cleared_pending", active_mask, 8'h00);

    // 2: seat 6 only
    mask_in = 8'h40; mask_wr = 1'b1;
    pix(0, 120);
    mask_wr = 1'b0;
    check("pending_not_active", active_mask, 8'h00);
    next_frame();
    check("active_seat6", active_mask, 8'h40);
    pix(407, 362);
    check("seat6_rom00", rgb, 12'h001);
    check("seat6_idx", hit_seat, 3'd6);
    check("seat6_valid", hit_valid, 1'b1);
    pix(406, 362);
    check("seat6_left_edge_bg", rgb, BG);
    check("seat6_left_edge_valid", hit_valid, 1'b0);
    pix(408, 363);
    check("seat6_rom11", rgb, 12'h043);
    pix(434, 396);
    check("seat6_last_row", rgb, 12'h8B7);
    pix(434, 397);
    check("seat6_below_bg", rgb, BG);

    // 3: key colour transparency and blanking
    pix(435, 362);
    check("key_is_bg", rgb, BG);
    check("key_no_valid", hit_valid, 1'b0);
    bright = 1'b0;
    pix(408, 363);
    check("blank_rgb", rgb, 12'h000);
    check("blank_valid", hit_valid, 1'b0);
    bright = 1'b1;

    // 4: mid-frame write to seat 0 takes effect only after the 524->0 wrap
    mask_in = 8'h01; mask_wr = 1'b1;
    pix(0, 200);
    mask_wr = 1'b0;
    pix(297, 307);
    check("seat0_not_yet", rgb, BG);
    pix(0, 524);
    pix(0, 0);
    check("active_seat0", active_mask, 8'h01);
    pix(297, 307);
    check("seat0_rom00", rgb, 12'h001);
    check("seat0_idx", hit_seat, 3'd0);
    pix(407, 362);
    check("seat6_gone", rgb, BG);

    // 6: write coincident with a frame boundary
    mask_in = 8'h40;
    pix(0, 100);
    mask_wr = 1'b1;
    pix(0, 0);
    mask_wr = 1'b0;
    check("fb_coincident_prior", active_mask, 8'h01);
    next_frame();
    check("fb_coincident_next", active_mask, 8'h40);

    // 5: blink over frames 0..6, then drop blink_en mid hidden frame
    blink_en = 1'b1;
    for (int f = 0; f < 7; f++) begin
      if (f != 0) next_frame();
      pix(407, 362);
      check($sformatf("blink_f%0d", f), rgb, BLINK_VIS[f] ? 12'h001 : BG);
    end
    blink_en = 1'b0;
    pix(407, 362);
    check("blink_off_visible", rgb, 12'h001);

    // Reset mid-frame blanks at once, background returns the next cycle
    rst = 1'b1;
    pix(407, 362);
    check("midreset_rgb", rgb, 12'h000);
    check("midreset_active", active_mask, 8'h00);
    rst = 1'b0;
    pix(407, 362);
    check("midreset_bg", rgb, BG);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
